// File: rtl/regfile_pkg.sv
// Shared sizing constants for the 32 x 64-bit register file.
package regfile_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  // XZR: reads as zero, writes are discarded, no storage behind it.
  localparam int unsigned XZR_ADDR = 31;

endpackage

// File: rtl/regfile_32x64_if.sv
// Register-file access bus: one write port, two combinational read ports.
interface regfile_32x64_if #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
);

  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );

endinterface

// File: rtl/regfile_32x64_decoder5_32.sv
// One-hot write-enable decoder: 5-to-32 built from a 2-to-4 stage
// selecting one of four 3-to-8 decoders.

module decoder2_4 (
  input  logic       en,
  input  logic [1:0] in,
  output logic [3:0] out
);
  // One-hot select, all zero when disabled
  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end
endmodule

module decoder3_8 (
  input  logic       en,
  input  logic [2:0] in,
  output logic [7:0] out
);
  // One-hot select, all zero when disabled
  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end
endmodule

module decoder5_32 (
  input  logic        en,
  input  logic [4:0]  in,
  output logic [31:0] out
);
  logic [3:0] w_grp;

  decoder2_4 u_hi (
    .en  (en),
    .in  (in[4:3]),
    .out (w_grp)
  );

  for (genvar g = 0; g < 4; g++) begin : g_lo
    decoder3_8 u_lo (
      .en  (w_grp[g]),
      .in  (in[2:0]),
      .out (out[8*g +: 8])
    );
  end
endmodule

// File: rtl/regfile_32x64.sv
// 32-entry register file, X31 hard-wired to zero, two combinational
// read ports with write-to-read bypass, asynchronous active-low reset.
module regfile_32x64 #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  regfile_32x64_if.slave        bus
);
  import regfile_pkg::*;

  // Storage for X0..X30 only; X31 has no flops.
  logic [DATA_W-1:0]   r_regs   [NUM_REGS-1];
  logic [DATA_W-1:0]   w_rd_vec [NUM_REGS];
  logic [NUM_REGS-1:0] w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [ADDR_W-1:0]   w_ra1;
  logic [ADDR_W-1:0]   w_ra2;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rd1;
  logic [DATA_W-1:0]   w_rd2;
  logic                w_byp_ok;

  assign w_waddr = bus.WriteRegister;
  assign w_wdata = bus.WriteData;
  assign w_ra1   = bus.ReadRegister1;
  assign w_ra2   = bus.ReadRegister2;

  decoder5_32 u_dec (
    .en  (bus.RegWrite),
    .in  (w_waddr[4:0]),
    .out (w_we)
  );

  // Capture write data into the one enabled register; clear all on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
        if (w_we[i]) r_regs[i] <= w_wdata;
      end
    end
  end

  // Mux source vector with the XZR slot tied to zero
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) w_rd_vec[i] = r_regs[i];
    w_rd_vec[XZR_ADDR] = '0;
  end

  // Bypass is only legal for a live write that is not aimed at XZR;
  // the decoder's XZR line doubles as that qualifier.
  assign w_byp_ok = bus.RegWrite && !w_we[XZR_ADDR];

  // Read port 1: bypass newest write data, forced to zero during reset
  always_comb begin
    w_rd1 = '0;
    if (reset_n) begin
      if (w_byp_ok && (w_waddr == w_ra1)) w_rd1 = w_wdata;
      else                                w_rd1 = w_rd_vec[w_ra1];
    end
  end

  // Read port 2: same structure as port 1, fully independent
  always_comb begin
    w_rd2 = '0;
    if (reset_n) begin
      if (w_byp_ok && (w_waddr == w_ra2)) w_rd2 = w_wdata;
      else                                w_rd2 = w_rd_vec[w_ra2];
    end
  end

  assign bus.ReadData1 = w_rd1;
  assign bus.ReadData2 = w_rd2;

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64.
module tb_regfile_32x64;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  regfile_32x64_if #(.DATA_W(64), .ADDR_W(5)) bif ();

  regfile_32x64 #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [63:0] exp1;
    logic [63:0] exp2;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bif.RegWrite      = we;
    bif.WriteRegister = wa;
    bif.WriteData     = wd;
    bif.ReadRegister1 = ra1;
    bif.ReadRegister2 = ra2;
  endtask

  initial begin
    logic [63:0] e1;
    logic [63:0] e2;
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'h0, 64'h0};
    vecs[1]  = '{1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 64'h0, 64'h0};
    vecs[2]  = '{1'b1, 5'd7,  64'hABCD, 5'd7,  5'd8,  64'hABCD, 64'h1008};
    vecs[3]  = '{1'b0, 5'd3,  64'h55,   5'd7,  5'd3,  64'hABCD, 64'h1003};
    vecs[4]  = '{1'b0, 5'd3,  64'h55,   5'd3,  5'd3,  64'h1003, 64'h1003};
    vecs[5]  = '{1'b0, 5'd3,  64'h55,   5'd3,  5'd7,  64'h1003, 64'hABCD};
    vecs[6]  = '{1'b1, 5'd12, 64'h1234, 5'd12, 5'd12, 64'h1234, 64'h1234};
    vecs[7]  = '{1'b0, 5'd12, 64'h1234, 5'd12, 5'd12, 64'h1234, 64'h1234};
    vecs[8]  = '{1'b1, 5'd0,  64'hFEDC_BA98_7654_3210, 5'd0, 5'd1, 64'hFEDC_BA98_7654_3210, 64'h1001};
    vecs[9]  = '{1'b1, 5'd30, 64'h8000_0000_0000_0001, 5'd0, 5'd30, 64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001};
    vecs[10] = '{1'b0, 5'd30, 64'h0, 5'd30, 5'd31, 64'h8000_0000_0000_0001, 64'h0};

    // Reset held with a write attempted: reads and bypass stay zero
    reset_n = 1'b0;
    drive(1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd5);
    #1;
    check("rst_rd1", bif.ReadData1, 64'h0);
    check("rst_rd2", bif.ReadData2, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_ignored", bif.ReadData1, 64'h0);

    // Release reset mid-cycle with no write; X5 must still be zero
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 5'd5, 64'hDEAD, 5'd5, 5'd5);
    #1;
    check("post_rst_x5", bif.ReadData1, 64'h0);

    // Load X5 then assert reset between edges
    @(negedge clk);
    drive(1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd4);
    @(negedge clk);
    drive(1'b0, 5'd5, 64'h0, 5'd5, 5'd4);
    #1;
    check("x5_loaded", bif.ReadData1, 64'hDEAD);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_x5", bif.ReadData1, 64'h0);

    // Deassert mid-cycle with write pending: bypass live, storage on edge
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 5'd4, 64'h44, 5'd4, 5'd5);
    #1;
    check("rel_byp_x4", bif.ReadData1, 64'h44);
    check("rel_x5_zero", bif.ReadData2, 64'h0);
    @(negedge clk);
    drive(1'b0, 5'd4, 64'h0, 5'd4, 5'd5);
    #1;
    check("rel_x4_stored", bif.ReadData1, 64'h44);

    // Write X0..X30 with 0x1000+i, then read back on both ports
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 64'h1000 + 64'(i), 5'd0, 5'd0);
    end
    @(negedge clk);
    bif.RegWrite = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bif.ReadRegister1 = 5'(i);
      bif.ReadRegister2 = 5'(31 - i);
      #1;
      e1 = (i == 31) ? 64'h0 : 64'h1000 + 64'(i);
      e2 = (i == 0)  ? 64'h0 : 64'h1000 + 64'(31 - i);
      check($sformatf("rdall1_x%0d", i), bif.ReadData1, e1);
      check($sformatf("rdall2_x%0d", 31 - i), bif.ReadData2, e2);
    end

    // Table-driven vectors: one per cycle, checked before the edge
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
      #1;
      check($sformatf("vec%0d_rd1", v), bif.ReadData1, vecs[v].exp1);
      check($sformatf("vec%0d_rd2", v), bif.ReadData2, vecs[v].exp2);
    end

    // RegWrite pulsed between edges: no effect on X20
    @(negedge clk);
    drive(1'b1, 5'd20, 64'hBAD, 5'd20, 5'd21);
    #2;
    bif.RegWrite = 1'b0;
    @(negedge clk);
    #1;
    check("glitch_we_x20", bif.ReadData1, 64'h1014);

    // Address changed before the edge: only the sampled address is written
    drive(1'b1, 5'd21, 64'h2121, 5'd21, 5'd22);
    #2;
    bif.WriteRegister = 5'd22;
    @(negedge clk);
    bif.RegWrite = 1'b0;
    #1;
    check("addr_chg_x21", bif.ReadData1, 64'h1015);
    check("addr_chg_x22", bif.ReadData2, 64'h2121);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
